// File: rtl/power_timer.sv
// rtl/power_timer.sv - multi-channel start-triggered counter/timer with power-enable and done pulse
// Optional per-channel tick prescaler enabled by defining POWER_TIMER_PRESCALE_EN.
module power_timer #(
  parameter int WIDTH    = 16,
  parameter int CH       = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         rstart,
  input  logic [CH-1:0]         stop,
  input  logic [CH-1:0]         mode,
  input  logic [CH*WIDTH-1:0]   load_val,
  output logic [CH*WIDTH-1:0]   count,
  output logic [CH-1:0]         power,
  output logic [CH-1:0]         done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef POWER_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
`endif

  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    logic             s1, s2, s3;
    logic             start_evt;
    logic             tick;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    // s1/s2 resolve metastability; s3 gives the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        s3 <= 1'b0;
      end else begin
        s1 <= rstart[i];
        s2 <= s1;
        s3 <= s2;
      end
    end

    assign start_evt = s2 & ~s3;

`ifdef POWER_TIMER_PRESCALE_EN
    logic [PW-1:0] presc_q, presc_d;

    assign tick = (presc_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        t_q     <= '0;
        mode_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        t_q     <= t_d;
        mode_q  <= mode_d;
        done_q  <= done_d;
      end
    end

    // Priority: stop, then (re)start, then counting; a restart never emits done.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t_d     = t_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
`ifdef POWER_TIMER_PRESCALE_EN
      presc_d = presc_q;
`endif
      if (stop[i]) begin
        state_d = IDLE;
      end else if (start_evt) begin
        state_d = RUN;
        cnt_d   = '0;
        t_d     = load_val[i*WIDTH +: WIDTH];
        mode_d  = mode[i];
`ifdef POWER_TIMER_PRESCALE_EN
        presc_d = '0;
`endif
      end else if (state_q == RUN) begin
`ifdef POWER_TIMER_PRESCALE_EN
        presc_d = tick ? '0 : presc_q + 1'b1;
`endif
        if (tick) begin
          if (cnt_q == t_q) begin
            done_d = 1'b1;
            if (mode_q) cnt_d   = '0;
            else        state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign power[i]                = (state_q == RUN);
    assign done[i]                 = done_q;
  end

endmodule

// File: tb/tb_power_timer.sv
// tb/tb_power_timer.sv - directed self-checking bench for power_timer (CH=2, WIDTH=8)
// Prescaler scenario runs only when POWER_TIMER_PRESCALE_EN is defined.
module tb_power_timer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rstart;
  logic [1:0]  stop;
  logic [1:0]  mode;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [1:0]  power;
  logic [1:0]  done;

  int total = 0;
  int bad   = 0;

  power_timer #(.WIDTH(8), .CH(2), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rstart   (rstart),
    .stop     (stop),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .power    (power),
    .done     (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: 27ns pulse straddling the next rising edge.
  task automatic start_pulse(input int ch);
    #5  rstart[ch] = 1'b1;
    #27 rstart[ch] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rstart = '0; stop = '0; mode = '0; load_val = '0;
    #15;
    check("rst count", count, 0);
    check("rst power", power, 0);
    check("rst done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post-rst count", count, 0);
    check("post-rst power", power, 0);

`ifndef POWER_TIMER_PRESCALE_EN
    // one-shot T=5 on ch0
    mode[0] = 1'b0; load_val[7:0] = 8'd5;
    start_pulse(0);
    @(negedge clk); check("t2 power before E2", power[0], 0);
    @(negedge clk); check("t2 count start", count[7:0], 0); check("t2 power on", power[0], 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t2 count", count[7:0], k);
      check("t2 done low", done[0], 0);
      check("t2 power", power[0], 1);
    end
    @(negedge clk);
    check("t2 done pulse", done[0], 1); check("t2 power off", power[0], 0); check("t2 count hold", count[7:0], 5);
    @(negedge clk);
    check("t2 done single", done[0], 0); check("t2 count hold2", count[7:0], 5);

    // periodic T=3 on ch1, then stop
    mode[1] = 1'b1; load_val[15:8] = 8'd3;
    start_pulse(1);
    @(negedge clk);
    @(negedge clk); check("t3 count start", count[15:8], 0); check("t3 power on", power[1], 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("t3 count", count[15:8], k % 4);
      check("t3 done", done[1], 32'((k % 4) == 0));
      check("t3 power", power[1], 1);
      check("t3 ch0 quiet", done[0], 0);
    end
    stop[1] = 1'b1;
    @(negedge clk); stop[1] = 1'b0;
    check("t3 stop power", power[1], 0); check("t3 stop count", count[15:8], 1); check("t3 stop done", done[1], 0);
    repeat (4) begin
      @(negedge clk);
      check("t3 no done after stop", done[1], 0);
      check("t3 count frozen", count[15:8], 1);
    end

    // restart mid-run with new terminal value
    mode[0] = 1'b0; load_val[7:0] = 8'd10;
    start_pulse(0);
    @(negedge clk);
    @(negedge clk); check("t4 count start", count[7:0], 0);
    repeat (7) @(negedge clk);
    check("t4 count 7", count[7:0], 7);
    load_val[7:0] = 8'd2;
    start_pulse(0);
    @(negedge clk); check("t4 count 9", count[7:0], 9); check("t4 no done", done[0], 0);
    @(negedge clk); check("t4 restart count", count[7:0], 0); check("t4 restart power", power[0], 1);
    check("t4 restart no done", done[0], 0);
    @(negedge clk); check("t4 count 1", count[7:0], 1);
    @(negedge clk); check("t4 count 2", count[7:0], 2); check("t4 done low", done[0], 0);
    @(negedge clk); check("t4 done", done[0], 1); check("t4 power off", power[0], 0); check("t4 count hold", count[7:0], 2);
    check("t4 ch1 count", count[15:8], 1); check("t4 ch1 power", power[1], 0);

    // stop coincident with start_evt
    start_pulse(0);
    stop[0] = 1'b1;
    @(negedge clk);
    @(negedge clk); stop[0] = 1'b0;
    check("t5a power", power[0], 0); check("t5a count", count[7:0], 2); check("t5a done", done[0], 0);
    @(negedge clk); check("t5a power later", power[0], 0); check("t5a done later", done[0], 0);

    // stop coincident with terminal count
    load_val[7:0] = 8'd3;
    start_pulse(0);
    @(negedge clk);
    @(negedge clk); check("t5b count start", count[7:0], 0); check("t5b power", power[0], 1);
    repeat (3) @(negedge clk);
    check("t5b count T", count[7:0], 3);
    stop[0] = 1'b1;
    @(negedge clk); stop[0] = 1'b0;
    check("t5b power off", power[0], 0); check("t5b no done", done[0], 0); check("t5b count hold", count[7:0], 3);
    @(negedge clk); check("t5b no done later", done[0], 0);

    // one-shot T=0
    load_val[7:0] = 8'd0;
    start_pulse(0);
    @(negedge clk); check("t5c power early", power[0], 0);
    @(negedge clk); check("t5c power on", power[0], 1); check("t5c count", count[7:0], 0); check("t5c done low", done[0], 0);
    @(negedge clk); check("t5c power off", power[0], 0); check("t5c done", done[0], 1); check("t5c count hold", count[7:0], 0);
    @(negedge clk); check("t5c done single", done[0], 0); check("t5c power stays off", power[0], 0);
`else
    // prescaled one-shot T=2, PRESCALE=4
    mode[0] = 1'b0; load_val[7:0] = 8'd2;
    start_pulse(0);
    @(negedge clk); check("t6 power early", power[0], 0);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      check("t6 power", power[0], 32'(k < 12));
      check("t6 count", count[7:0], (k < 12) ? k / 4 : 2);
      check("t6 done", done[0], 32'(k == 12));
      @(negedge clk);
    end
`endif

    // reset mid-run clears immediately, no done
    mode[0] = 1'b0; load_val[7:0] = 8'd5;
    start_pulse(0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t1 running", power[0], 1);
    #5 rst_n = 1'b0;
    #1;
    check("t1 async count", count, 0); check("t1 async power", power, 0); check("t1 async done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("t1 no done", done, 0);
      check("t1 no power", power, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
